// File: rtl/user_pkg.sv
// User-domain address map shared by the user-domain interconnect.
// Holds the subordinate count, the inclusive start/end address rules
// (slice i of the flattened vectors is rule i) and the data pattern the
// error subordinate returns on unmapped accesses.
package user_pkg;

    localparam int unsigned NumUserDomainSubordinates = 2;

    // Subordinate 0: ROM, subordinate 1: CNN accelerator.
    localparam logic [31:0] UserRomStart = 32'h2000_0000;
    localparam logic [31:0] UserRomEnd   = 32'h2000_0FFF;
    localparam logic [31:0] UserCnnStart = 32'h2000_1000;
    localparam logic [31:0] UserCnnEnd   = 32'h2001_4FFF;

    localparam logic [NumUserDomainSubordinates*32-1:0] UserRuleStart = {UserCnnStart, UserRomStart};
    localparam logic [NumUserDomainSubordinates*32-1:0] UserRuleEnd   = {UserCnnEnd,   UserRomEnd};

    // Read data returned for accesses that hit no rule.
    localparam logic [31:0] ErrorRdata = 32'hBADCAB1E;

endpackage

// File: rtl/user_obi_err_sbr.sv
// Error subordinate for the user-domain demux.
// Accepts every request it is handed and answers exactly one cycle later
// with err=1, rdata=ErrorRdata and the request's id.
// Ports:
//   clk_i, rst_ni      clock, async active-low reset
//   req_i              accepted request (handshake already qualified)
//   aid_i              request id
//   rvalid_o/rdata_o/rid_o/err_o  response, all zero when not valid
module user_obi_err_sbr
    import user_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic [IdWidth-1:0]   aid_i,
    output logic                 rvalid_o,
    output logic [DataWidth-1:0] rdata_o,
    output logic [IdWidth-1:0]   rid_o,
    output logic                 err_o
);

    localparam logic [DataWidth-1:0] ErrData = DataWidth'(ErrorRdata);

    logic               r_valid;
    logic [IdWidth-1:0] r_rid;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_rid   <= '0;
        end else begin
            r_valid <= req_i;
            if (req_i) r_rid <= aid_i;
        end
    end

    assign rvalid_o = r_valid;
    assign rdata_o  = r_valid ? ErrData : '0;
    assign rid_o    = r_valid ? r_rid : '0;
    assign err_o    = r_valid;

endmodule

// File: rtl/user_obi_addr_demux.sv
// OBI address demultiplexer for the user domain.
// Routes one manager port to NumSbr subordinates by an inclusive
// start/end rule table; unmapped addresses go to an internal error
// subordinate (index NumSbr). Responses return in order: a request to a
// different subordinate is held off until every outstanding response of
// the current one has come back.
// Ports:
//   clk_i, rst_ni                       clock, async active-low reset
//   mgr_*                               manager request / response port
//   sbr_req_o, sbr_gnt_i                per-subordinate request / grant
//   sbr_addr_o..sbr_aid_o               broadcast request payload
//   sbr_rvalid_i/rdata_i/rid_i/err_i    per-subordinate responses (flattened)
module user_obi_addr_demux
    import user_pkg::*;
#(
    parameter int unsigned NumSbr    = NumUserDomainSubordinates,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned MaxTrans  = 4,
    parameter logic [NumSbr*AddrWidth-1:0] RuleStart = UserRuleStart,
    parameter logic [NumSbr*AddrWidth-1:0] RuleEnd   = UserRuleEnd
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        mgr_req_i,
    output logic                        mgr_gnt_o,
    input  logic [AddrWidth-1:0]        mgr_addr_i,
    input  logic                        mgr_we_i,
    input  logic [DataWidth/8-1:0]      mgr_be_i,
    input  logic [DataWidth-1:0]        mgr_wdata_i,
    input  logic [IdWidth-1:0]          mgr_aid_i,
    output logic                        mgr_rvalid_o,
    output logic [DataWidth-1:0]        mgr_rdata_o,
    output logic [IdWidth-1:0]          mgr_rid_o,
    output logic                        mgr_err_o,
    output logic [NumSbr-1:0]           sbr_req_o,
    input  logic [NumSbr-1:0]           sbr_gnt_i,
    output logic [AddrWidth-1:0]        sbr_addr_o,
    output logic                        sbr_we_o,
    output logic [DataWidth/8-1:0]      sbr_be_o,
    output logic [DataWidth-1:0]        sbr_wdata_o,
    output logic [IdWidth-1:0]          sbr_aid_o,
    input  logic [NumSbr-1:0]           sbr_rvalid_i,
    input  logic [NumSbr*DataWidth-1:0] sbr_rdata_i,
    input  logic [NumSbr*IdWidth-1:0]   sbr_rid_i,
    input  logic [NumSbr-1:0]           sbr_err_i
);

    localparam int unsigned SelW = $clog2(NumSbr + 1);
    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam logic [SelW-1:0] ErrSel = SelW'(NumSbr);
    localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

    // Rules must be well formed and pairwise disjoint.
    function automatic bit rules_valid();
        bit ok = 1'b1;
        for (int i = 0; i < NumSbr; i++) begin
            if (RuleStart[i*AddrWidth +: AddrWidth] > RuleEnd[i*AddrWidth +: AddrWidth]) ok = 1'b0;
            for (int j = i + 1; j < NumSbr; j++) begin
                if (!(RuleEnd[i*AddrWidth +: AddrWidth] < RuleStart[j*AddrWidth +: AddrWidth] ||
                      RuleEnd[j*AddrWidth +: AddrWidth] < RuleStart[i*AddrWidth +: AddrWidth])) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    if (MaxTrans < 1) begin : g_bad_maxtrans
        $error("user_obi_addr_demux: MaxTrans must be at least 1");
    end
    if (!rules_valid()) begin : g_bad_rules
        $error("user_obi_addr_demux: address rules overlap or have start > end");
    end

    logic [CntW-1:0]      r_cnt;
    logic [SelW-1:0]      r_last_sel;
    logic [SelW-1:0]      w_sel;
    logic                 w_permit;
    logic                 w_sel_gnt;
    logic                 w_hs;
    logic                 w_rsp_fire;
    logic [DataWidth-1:0] w_rdata;
    logic [IdWidth-1:0]   w_rid;
    logic                 w_rerr;
    logic [NumSbr-1:0]    w_last_onehot;
    logic                 w_err_rvalid;
    logic [DataWidth-1:0] w_err_rdata;
    logic [IdWidth-1:0]   w_err_rid;
    logic                 w_err_err;

    // Lowest-indexed matching rule wins; iterate downwards so it is written last.
    always_comb begin
        w_sel = ErrSel;
        for (int i = NumSbr - 1; i >= 0; i--) begin
            if (mgr_addr_i >= RuleStart[i*AddrWidth +: AddrWidth] &&
                mgr_addr_i <= RuleEnd[i*AddrWidth +: AddrWidth]) begin
                w_sel = SelW'(i);
            end
        end
    end

    // Switching target only when nothing is outstanding keeps responses ordered.
    assign w_permit = rst_ni && mgr_req_i && (r_cnt < CntMax) &&
                      (r_cnt == '0 || w_sel == r_last_sel);

    always_comb begin
        w_sel_gnt = 1'b1;  // the error subordinate accepts immediately
        sbr_req_o = '0;
        for (int i = 0; i < NumSbr; i++) begin
            if (w_sel == SelW'(i)) begin
                w_sel_gnt    = sbr_gnt_i[i];
                sbr_req_o[i] = w_permit;
            end
        end
    end

    assign mgr_gnt_o = w_permit && w_sel_gnt;
    assign w_hs      = mgr_gnt_o;

    assign sbr_addr_o  = rst_ni ? mgr_addr_i  : '0;
    assign sbr_we_o    = rst_ni ? mgr_we_i    : 1'b0;
    assign sbr_be_o    = rst_ni ? mgr_be_i    : '0;
    assign sbr_wdata_o = rst_ni ? mgr_wdata_i : '0;
    assign sbr_aid_o   = rst_ni ? mgr_aid_i   : '0;

    user_obi_err_sbr #(
        .DataWidth (DataWidth),
        .IdWidth   (IdWidth)
    ) u_err_sbr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (w_hs && (w_sel == ErrSel)),
        .aid_i    (mgr_aid_i),
        .rvalid_o (w_err_rvalid),
        .rdata_o  (w_err_rdata),
        .rid_o    (w_err_rid),
        .err_o    (w_err_err)
    );

    always_comb begin
        w_rsp_fire    = 1'b0;
        w_rdata       = '0;
        w_rid         = '0;
        w_rerr        = 1'b0;
        w_last_onehot = '0;
        if (r_last_sel == ErrSel) begin
            w_rsp_fire = w_err_rvalid;
            w_rdata    = w_err_rdata;
            w_rid      = w_err_rid;
            w_rerr     = w_err_err;
        end
        for (int i = 0; i < NumSbr; i++) begin
            if (r_last_sel == SelW'(i)) begin
                w_rsp_fire       = sbr_rvalid_i[i];
                w_rdata          = sbr_rdata_i[i*DataWidth +: DataWidth];
                w_rid            = sbr_rid_i[i*IdWidth +: IdWidth];
                w_rerr           = sbr_err_i[i];
                w_last_onehot[i] = 1'b1;
            end
        end
        // With nothing outstanding any response is stale (e.g. issued
        // before a reset) and must not reach the manager.
        if (r_cnt == '0) w_rsp_fire = 1'b0;
    end

    assign mgr_rvalid_o = w_rsp_fire;
    assign mgr_rdata_o  = w_rsp_fire ? w_rdata : '0;
    assign mgr_rid_o    = w_rsp_fire ? w_rid   : '0;
    assign mgr_err_o    = w_rsp_fire && w_rerr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= '0;
            r_last_sel <= '0;
        end else begin
            if (w_hs) r_last_sel <= w_sel;
            if (w_hs && !w_rsp_fire)      r_cnt <= r_cnt + CntW'(1);
            else if (!w_hs && w_rsp_fire) r_cnt <= r_cnt - CntW'(1);
        end
    end

`ifndef SYNTHESIS
    // A subordinate other than the current target must not respond while
    // transactions are outstanding.
    a_rsp_from_unselected: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_cnt != '0) |-> ((sbr_rvalid_i & ~w_last_onehot) == '0));
`endif

endmodule

// File: tb/tb_user_obi_addr_demux.sv
module tb_user_obi_addr_demux;
    localparam int MT = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mgr_req_i = 1'b0;
    logic        mgr_gnt_o;
    logic [31:0] mgr_addr_i = '0;
    logic        mgr_we_i = 1'b0;
    logic [3:0]  mgr_be_i = '0;
    logic [31:0] mgr_wdata_i = '0;
    logic [0:0]  mgr_aid_i = '0;
    logic        mgr_rvalid_o;
    logic [31:0] mgr_rdata_o;
    logic [0:0]  mgr_rid_o;
    logic        mgr_err_o;
    logic [1:0]  sbr_req_o;
    logic [1:0]  sbr_gnt_i = '0;
    logic [31:0] sbr_addr_o;
    logic        sbr_we_o;
    logic [3:0]  sbr_be_o;
    logic [31:0] sbr_wdata_o;
    logic [0:0]  sbr_aid_o;
    logic [1:0]  sbr_rvalid_i = '0;
    logic [63:0] sbr_rdata_i = '0;
    logic [1:0]  sbr_rid_i = '0;
    logic [1:0]  sbr_err_i = '0;

    user_obi_addr_demux dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o), .mgr_addr_i(mgr_addr_i),
        .mgr_we_i(mgr_we_i), .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i), .mgr_aid_i(mgr_aid_i),
        .mgr_rvalid_o(mgr_rvalid_o), .mgr_rdata_o(mgr_rdata_o), .mgr_rid_o(mgr_rid_o), .mgr_err_o(mgr_err_o),
        .sbr_req_o(sbr_req_o), .sbr_gnt_i(sbr_gnt_i), .sbr_addr_o(sbr_addr_o), .sbr_we_o(sbr_we_o),
        .sbr_be_o(sbr_be_o), .sbr_wdata_o(sbr_wdata_o), .sbr_aid_o(sbr_aid_o),
        .sbr_rvalid_i(sbr_rvalid_i), .sbr_rdata_i(sbr_rdata_i), .sbr_rid_i(sbr_rid_i), .sbr_err_i(sbr_err_i)
    );

    always #5 clk_i = ~clk_i;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Reference model: outstanding count, their target, error responder due.
    int   n_out = 0;
    int   tgt = 0;
    bit   err_due = 0;
    logic err_id = 0;
    bit   last_gnt = 0;
    int   cyc = 0;

    // Subordinate models: in-order response queues.
    typedef struct {
        logic [31:0] data;
        logic        id;
        logic        err;
        int          ready;
    } rsp_t;
    rsp_t sq[2][$];
    bit   drv[2];
    bit   gnt_rand = 1;
    logic [1:0] gnt_force = 2'b00;
    int   rsp_pct = 100;
    int   dly_min = 0;
    int   dly_max = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    function automatic int ref_sel(logic [31:0] a);
        if (a >= 32'h2000_0000 && a <= 32'h2000_0FFF) return 0;
        if (a >= 32'h2000_1000 && a <= 32'h2001_4FFF) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        case ($urandom_range(0, 9))
            0: a = 32'h2000_0FFF;
            1: a = 32'h2000_1000;
            2: a = 32'h2001_4FFF;
            3: a = 32'h2001_5000;
            4: a = 32'h1FFF_FFFF;
            5, 6: a = 32'h2000_0000 | ($urandom & 32'h0000_0FFC);
            7, 8: a = 32'h2000_1000 + ($urandom_range(0, 32'h13FFF) & 32'hFFFF_FFFC);
            default: a = $urandom;
        endcase
        return a;
    endfunction

    task automatic drive_subs();
        for (int s = 0; s < 2; s++) begin
            sbr_gnt_i[s] = gnt_rand ? ($urandom_range(0, 99) < 60) : gnt_force[s];
            drv[s] = (sq[s].size() > 0) && (sq[s][0].ready <= cyc) &&
                     ($urandom_range(0, 99) < rsp_pct);
            sbr_rvalid_i[s] = drv[s];
            if (drv[s]) begin
                sbr_rdata_i[s*32 +: 32] = sq[s][0].data;
                sbr_rid_i[s] = sq[s][0].id;
                sbr_err_i[s] = sq[s][0].err;
            end else begin
                // junk on idle lanes: must never leak to the manager
                sbr_rdata_i[s*32 +: 32] = $urandom;
                sbr_rid_i[s] = 1'($urandom);
                sbr_err_i[s] = 1'($urandom);
            end
        end
    endtask

    task automatic settle();
        #2;
    endtask

    // Compare DUT outputs with the model for this cycle, then advance a clock
    // and update the model with what happened at that edge.
    task automatic tick();
        int sel; bit perm; logic [1:0] ereq; bit egnt; bit fire;
        logic [31:0] edata; logic eid; bit eerr; bit rst_now; logic aid_now;
        bit drv_now[2];
        sel = ref_sel(mgr_addr_i);
        perm = rst_ni && mgr_req_i && (n_out < MT) && (n_out == 0 || sel == tgt);
        ereq = (perm && sel < 2) ? 2'(1 << sel) : 2'b00;
        egnt = perm && (sel == 2 ? 1'b1 : sbr_gnt_i[sel]);
        fire = 0; edata = '0; eid = 0; eerr = 0;
        if (rst_ni && n_out > 0 && tgt < 2 && drv[tgt]) begin
            fire = 1; edata = sq[tgt][0].data; eid = sq[tgt][0].id; eerr = sq[tgt][0].err;
        end else if (rst_ni && n_out > 0 && tgt == 2 && err_due) begin
            fire = 1; edata = 32'hBADCAB1E; eid = err_id; eerr = 1;
        end
        chk("sbr_req", 128'(sbr_req_o), 128'(ereq));
        chk("mgr_gnt", 128'(mgr_gnt_o), 128'(egnt));
        chk("payload", 128'({sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o, sbr_aid_o}),
            rst_ni ? 128'({mgr_addr_i, mgr_we_i, mgr_be_i, mgr_wdata_i, mgr_aid_i}) : 128'(0));
        chk("rsp", 128'({mgr_rvalid_o, mgr_rdata_o, mgr_rid_o, mgr_err_o}),
            128'({fire, edata, eid, eerr}));
        last_gnt = egnt;
        rst_now = rst_ni; aid_now = mgr_aid_i;
        drv_now[0] = drv[0]; drv_now[1] = drv[1];
        @(posedge clk_i); #1;
        cyc++;
        for (int s = 0; s < 2; s++) if (drv_now[s]) void'(sq[s].pop_front());
        if (!rst_now || !rst_ni) begin
            n_out = 0; tgt = 0; err_due = 0;
        end else begin
            if (egnt && sel < 2)
                sq[sel].push_back('{data: $urandom, id: aid_now, err: 1'($urandom),
                                    ready: cyc + $urandom_range(dly_min, dly_max)});
            err_due = egnt && sel == 2;
            err_id = aid_now;
            if (egnt) tgt = sel;
            n_out = n_out + int'(egnt) - int'(fire);
        end
    endtask

    task automatic set_req(bit r, logic [31:0] a, logic id);
        mgr_req_i = r; mgr_addr_i = a; mgr_aid_i = id;
        mgr_we_i = 1'($urandom); mgr_be_i = 4'($urandom); mgr_wdata_i = $urandom;
    endtask

    task automatic drain(int bound);
        int k;
        mgr_req_i = 0;
        k = 0;
        while ((n_out > 0 || sq[0].size() > 0 || sq[1].size() > 0) && k < bound) begin
            drive_subs(); settle(); tick(); k++;
        end
        chk("drain_done", 128'(n_out + sq[0].size() + sq[1].size()), 128'(0));
    endtask

    initial begin
        bit fired;
        gnt_rand = 0; rsp_pct = 100; dly_min = 0; dly_max = 0;

        // Reset: all outputs low even with a live request and grants.
        set_req(1, 32'h2000_0004, 0); gnt_force = 2'b11;
        drive_subs(); settle();
        chk("rst_req", 128'(sbr_req_o), 128'(0));
        chk("rst_gnt", 128'(mgr_gnt_o), 128'(0));
        chk("rst_addr", 128'(sbr_addr_o), 128'(0));
        tick(); tick();
        rst_ni = 1;

        // ROM read granted after 2 cycles, response with same rid.
        gnt_force = 2'b00;
        for (int k = 0; k < 2; k++) begin
            drive_subs(); settle();
            chk("rom_wait_req", 128'(sbr_req_o), 128'(2'b01));
            tick();
        end
        gnt_force = 2'b01;
        drive_subs(); settle();
        chk("rom_gnt", 128'(mgr_gnt_o), 128'(1));
        tick();
        set_req(0, 32'h0, 0);
        drive_subs(); settle();
        chk("rom_rvalid", 128'(mgr_rvalid_o), 128'(1));
        chk("rom_rid", 128'(mgr_rid_o), 128'(0));
        tick();

        // Unmapped access: same-cycle grant, error response next cycle.
        set_req(1, 32'h3000_0000, 1);
        drive_subs(); settle();
        chk("err_gnt", 128'(mgr_gnt_o), 128'(1));
        chk("err_noreq", 128'(sbr_req_o), 128'(0));
        tick();
        set_req(0, 32'h0, 0);
        drive_subs(); settle();
        chk("err_rsp", 128'({mgr_rvalid_o, mgr_err_o, mgr_rdata_o, mgr_rid_o}),
            128'({1'b1, 1'b1, 32'hBADCAB1E, 1'b1}));
        tick();

        // Switch stall: CNN outstanding blocks a ROM request until after its response.
        dly_min = 3; dly_max = 3; gnt_force = 2'b10;
        set_req(1, 32'h2000_1000, 0);
        drive_subs(); settle(); tick();
        set_req(1, 32'h2000_0000, 0); gnt_force = 2'b11;
        fired = 0;
        for (int k = 0; k < 10 && !fired; k++) begin
            drive_subs(); settle();
            fired = sbr_rvalid_i[1];
            chk("switch_stall_gnt", 128'({mgr_gnt_o, sbr_req_o}), 128'(0));
            tick();
        end
        chk("switch_rsp_seen", 128'(fired), 128'(1));
        drive_subs(); settle();
        chk("switch_gnt", 128'({mgr_gnt_o, sbr_req_o}), 128'({1'b1, 2'b01}));
        tick();
        dly_min = 0; dly_max = 0;
        drain(20);

        // MaxTrans: CNN silent, 5th request stalls.
        rsp_pct = 0; gnt_force = 2'b11;
        set_req(1, 32'h2000_1004, 1);
        for (int k = 0; k < MT; k++) begin
            drive_subs(); settle();
            chk("max_fill_gnt", 128'(mgr_gnt_o), 128'(1));
            tick();
        end
        drive_subs(); settle();
        chk("max_stall", 128'({mgr_gnt_o, sbr_req_o}), 128'(0));
        tick();
        rsp_pct = 100;
        drive_subs(); settle();
        chk("max_rsp_nognt", 128'({mgr_rvalid_o, mgr_gnt_o}), 128'({1'b1, 1'b0}));
        tick();
        drive_subs(); settle();
        chk("max_rsp_and_gnt", 128'({mgr_rvalid_o, mgr_gnt_o}), 128'({1'b1, 1'b1}));
        tick();
        drain(50);

        // Reset with 3 outstanding; late responses are dropped.
        rsp_pct = 0; gnt_force = 2'b10;
        set_req(1, 32'h2000_2000, 0);
        for (int k = 0; k < 3; k++) begin drive_subs(); settle(); tick(); end
        rst_ni = 0;
        drive_subs(); settle();
        chk("midrst_out", 128'({mgr_gnt_o, sbr_req_o, mgr_rvalid_o}), 128'(0));
        tick();
        rst_ni = 1; mgr_req_i = 0; rsp_pct = 100;
        for (int k = 0; k < 20 && (sq[0].size() > 0 || sq[1].size() > 0); k++) begin
            drive_subs(); settle();
            chk("late_rvalid", 128'(mgr_rvalid_o), 128'(0));
            tick();
        end

        // Randomized traffic against the model.
        gnt_rand = 1; rsp_pct = 70; dly_min = 0; dly_max = 3;
        mgr_req_i = 0; last_gnt = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!mgr_req_i || last_gnt)
                set_req($urandom_range(0, 99) < 70, pick_addr(), 1'($urandom));
            drive_subs(); settle(); tick();
        end
        rsp_pct = 100;
        drain(200);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
